// File: rtl/jtopl_pg_feed_pkg.sv
// Shared constants and slot-decode helpers for the phase-generator feed.
// Slots map to operators as g = s/6, w = s%6; operators sit at register offset 8g+w.
package jtopl_pg_feed_pkg;

    localparam int         SLOT_NUM   = 18;
    localparam int         SLOT_W     = 5;
    localparam logic [7:0] REG_OP     = 8'h20;
    localparam logic [7:0] REG_FNUM   = 8'hA0;
    localparam logic [7:0] REG_BLK    = 8'hB0;
    localparam logic [7:0] REG_RHY    = 8'hBD;
    localparam int         VIB_FRAMES = 1024;
    localparam int         FRAME_W    = $clog2(VIB_FRAMES);

    // Channel that owns slot s.
    function automatic logic [3:0] slot_ch(input logic [SLOT_W-1:0] s);
        int si;
        si = int'(s);
        return 4'(3 * (si / 6) + (si % 6) % 3);
    endfunction

    // Register address of the per-operator 0x20 entry for slot index si.
    function automatic logic [7:0] op_addr(input int si);
        return REG_OP + 8'(8 * (si / 6) + si % 6);
    endfunction

endpackage

// File: rtl/jtopl_slot_cnt.sv
// Slot sequencer: slot index and one-hot, frame counter and vibrato LFO step.
module jtopl_slot_cnt
    import jtopl_pg_feed_pkg::*;
#(
    parameter int SLOTS = SLOT_NUM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cenop,
    output logic [SLOT_W-1:0] s,
    output logic [SLOT_W-1:0] s_nxt,
    output logic [SLOTS-1:0]  slot,
    output logic [2:0]        vib_cnt
);

    localparam logic [SLOT_W-1:0]  LAST_SLOT  = SLOT_W'(SLOTS - 1);
    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(VIB_FRAMES - 1);

    logic [FRAME_W-1:0] frame_reg;

    assign s_nxt = (s == LAST_SLOT) ? '0 : s + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s         <= '0;
            slot      <= SLOTS'(1);
            frame_reg <= '0;
            vib_cnt   <= '0;
        end else if (cenop) begin
            s    <= s_nxt;
            slot <= {slot[SLOTS-2:0], slot[SLOTS-1]};
            if (s == LAST_SLOT) begin
                frame_reg <= frame_reg + 1'b1;
                if (frame_reg == LAST_FRAME)
                    vib_cnt <= vib_cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/jtopl_pg_feed.sv
// Register file and slot-ordered feed for the phase generator: stage-I channel data,
// stage-II operator multiplier and key-on phase reset.
module jtopl_pg_feed
    import jtopl_pg_feed_pkg::*;
#(
    parameter int CH = 9
) (
    input  logic            rst,
    input  logic            clk,
    input  logic            cenop,
    input  logic            wr,
    input  logic [7:0]      addr,
    input  logic [7:0]      din,
    output logic [2*CH-1:0] slot,
    output logic [9:0]      fnum_I,
    output logic [2:0]      block_I,
    output logic            viben_I,
    output logic [3:0]      mul_II,
    output logic            pg_rst_II,
    output logic [2:0]      vib_cnt,
    output logic            vib_dep,
    output logic            rhy_en
);

    localparam int SLOTS = 2 * CH;

    logic [SLOT_W-1:0] s;
    logic [SLOT_W-1:0] s_nxt;
    logic [3:0]        ch_nxt;

    logic [3:0]       mul_reg  [0:SLOTS-1];
    logic [SLOTS-1:0] vib_reg;
    logic [SLOTS-1:0] kon_seen_reg;
    logic [9:0]       fnum_reg [0:CH-1];
    logic [2:0]       block_reg[0:CH-1];
    logic [CH-1:0]    kon_reg;
    logic             pg_i_reg;

    logic [SLOTS-1:0] op_we;
    logic [CH-1:0]    fnum_we;
    logic [CH-1:0]    blk_we;
    logic             rhy_we;

    jtopl_slot_cnt #(
        .SLOTS(SLOTS)
    ) u_slot_cnt (
        .clk    (clk),
        .rst    (rst),
        .cenop  (cenop),
        .s      (s),
        .s_nxt  (s_nxt),
        .slot   (slot),
        .vib_cnt(vib_cnt)
    );

    // Address decode; unlisted addresses simply match nothing.
    genvar gi;
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_op_dec
            assign op_we[gi] = wr && (addr == op_addr(gi));
        end
        for (gi = 0; gi < CH; gi++) begin : g_ch_dec
            assign fnum_we[gi] = wr && (addr == REG_FNUM + 8'(gi));
            assign blk_we[gi]  = wr && (addr == REG_BLK + 8'(gi));
        end
    endgenerate

    assign rhy_we = wr && (addr == REG_RHY);
    assign ch_nxt = slot_ch(s_nxt);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++)
                mul_reg[i] <= '0;
            for (int i = 0; i < CH; i++) begin
                fnum_reg[i]  <= '0;
                block_reg[i] <= '0;
            end
            vib_reg      <= '0;
            kon_seen_reg <= '0;
            kon_reg      <= '0;
            pg_i_reg     <= 1'b0;
            vib_dep      <= 1'b0;
            rhy_en       <= 1'b0;
            fnum_I       <= '0;
            block_I      <= '0;
            viben_I      <= 1'b0;
            mul_II       <= '0;
            pg_rst_II    <= 1'b0;
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (op_we[i]) begin
                    mul_reg[i] <= din[3:0];
                    vib_reg[i] <= din[6];
                end
            end
            for (int i = 0; i < CH; i++) begin
                if (fnum_we[i])
                    fnum_reg[i][7:0] <= din;
                if (blk_we[i]) begin
                    kon_reg[i]       <= din[5];
                    block_reg[i]     <= din[4:2];
                    fnum_reg[i][9:8] <= din[1:0];
                end
            end
            if (rhy_we) begin
                vib_dep <= din[6];
                rhy_en  <= din[5];
            end
            // Same-cycle writes land after these reads, so a cenop sees pre-write data.
            if (cenop) begin
                fnum_I               <= fnum_reg[ch_nxt];
                block_I              <= block_reg[ch_nxt];
                viben_I              <= vib_reg[s_nxt];
                pg_i_reg             <= kon_reg[ch_nxt] & ~kon_seen_reg[s_nxt];
                kon_seen_reg[s_nxt]  <= kon_reg[ch_nxt];
                mul_II               <= mul_reg[s];
                pg_rst_II            <= pg_i_reg;
            end
        end
    end

endmodule

// File: tb/tb_jtopl_pg_feed.sv
// Directed bench for jtopl_pg_feed: table of register/slot vectors plus hand sequences
// for slot walk, key-on phase reset, vibrato step, write/cenop overlap and reset override.
module tb_jtopl_pg_feed;

    logic        rst;
    logic        clk;
    logic        cenop;
    logic        wr;
    logic [7:0]  addr;
    logic [7:0]  din;
    logic [17:0] slot;
    logic [9:0]  fnum_I;
    logic [2:0]  block_I;
    logic        viben_I;
    logic [3:0]  mul_II;
    logic        pg_rst_II;
    logic [2:0]  vib_cnt;
    logic        vib_dep;
    logic        rhy_en;

    int n_vec  = 0;
    int n_miss = 0;

    jtopl_pg_feed #(.CH(9)) dut (
        .rst      (rst),
        .clk      (clk),
        .cenop    (cenop),
        .wr       (wr),
        .addr     (addr),
        .din      (din),
        .slot     (slot),
        .fnum_I   (fnum_I),
        .block_I  (block_I),
        .viben_I  (viben_I),
        .mul_II   (mul_II),
        .pg_rst_II(pg_rst_II),
        .vib_cnt  (vib_cnt),
        .vib_dep  (vib_dep),
        .rhy_en   (rhy_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a0;
        logic [7:0] d0;
        logic [7:0] a1;
        logic [7:0] d1;
        int         s;
        logic [9:0] fnum;
        logic [2:0] blk;
        logic       vib;
        logic [3:0] mul;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // One clock: inputs applied between edges, outputs sampled 1 time unit after the edge.
    task automatic step(input logic c, input logic w, input logic [7:0] a, input logic [7:0] d);
        cenop = c;
        wr    = w;
        addr  = a;
        din   = d;
        @(posedge clk);
        #1;
        cenop = 1'b0;
        wr    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(0, 0, 8'h00, 8'h00);
        step(0, 0, 8'h00, 8'h00);
        rst = 1'b0;
    endtask

    // Advance with cenop until slot s is at stage I; returns 0 if the bound expires.
    task automatic seek(input int s, output bit found);
        logic [17:0] target;
        int cnt;
        target = 18'h1 << s;
        cnt = 0;
        step(1, 0, 8'h00, 8'h00);
        while (slot != target && cnt < 40) begin
            step(1, 0, 8'h00, 8'h00);
            cnt++;
        end
        found = (slot == target);
    endtask

    logic [17:0] exp_slot;
    bit          found;
    int          pulses;

    initial begin
        rst = 1'b0; cenop = 1'b0; wr = 1'b0; addr = 8'h00; din = 8'h00;

        //               a0     d0     a1     d1    s   fnum    blk   vib  mul
        vecs[0]  = '{8'hA4, 8'h55, 8'hB4, 8'h3A,  7, 10'h255, 3'd6, 1'b0, 4'h0};
        vecs[1]  = '{8'hA4, 8'h55, 8'hB4, 8'h3A, 10, 10'h255, 3'd6, 1'b0, 4'h0};
        vecs[2]  = '{8'hA4, 8'h55, 8'hB4, 8'h3A,  4, 10'h000, 3'd0, 1'b0, 4'h0};
        vecs[3]  = '{8'hA4, 8'h55, 8'hB4, 8'h3A, 13, 10'h000, 3'd0, 1'b0, 4'h0};
        vecs[4]  = '{8'h33, 8'h4C, 8'hFF, 8'h00, 15, 10'h000, 3'd0, 1'b1, 4'hC};
        vecs[5]  = '{8'h33, 8'h4C, 8'hFF, 8'h00, 14, 10'h000, 3'd0, 1'b0, 4'h0};
        vecs[6]  = '{8'h26, 8'hFF, 8'h2E, 8'hFF,  5, 10'h000, 3'd0, 1'b0, 4'h0};
        vecs[7]  = '{8'h26, 8'hFF, 8'h2E, 8'hFF,  6, 10'h000, 3'd0, 1'b0, 4'h0};
        vecs[8]  = '{8'hA8, 8'hFF, 8'hB8, 8'h1F, 17, 10'h3FF, 3'd7, 1'b0, 4'h0};
        vecs[9]  = '{8'hA9, 8'hFF, 8'hB9, 8'hFF, 17, 10'h000, 3'd0, 1'b0, 4'h0};
        vecs[10] = '{8'h20, 8'h0F, 8'hFF, 8'h00,  0, 10'h000, 3'd0, 1'b0, 4'hF};
        vecs[11] = '{8'h35, 8'h40, 8'hA0, 8'h80, 17, 10'h000, 3'd0, 1'b1, 4'h0};
        vecs[12] = '{8'h2D, 8'h4F, 8'hB3, 8'h0C, 11, 10'h000, 3'd0, 1'b1, 4'hF};
        vecs[13] = '{8'h2D, 8'h4F, 8'hB3, 8'h0C,  9, 10'h000, 3'd3, 1'b0, 4'h0};

        // Reset state and a full slot walk with idle registers.
        do_reset();
        chk("rst_slot", int'(slot), 18'h1);
        chk("rst_data", int'({fnum_I, block_I, viben_I, mul_II, pg_rst_II}), 0);
        chk("rst_misc", int'({vib_cnt, vib_dep, rhy_en}), 0);
        for (int i = 0; i < 18; i++) begin
            step(1, 0, 8'h00, 8'h00);
            exp_slot = 18'h1 << ((i + 1) % 18);
            chk($sformatf("walk_slot[%0d]", i), int'(slot), int'(exp_slot));
            chk($sformatf("walk_data[%0d]", i),
                int'({fnum_I, block_I, viben_I, mul_II, pg_rst_II}), 0);
        end

        // Table-driven register/slot vectors.
        for (int v = 0; v < 14; v++) begin
            do_reset();
            step(0, 1, vecs[v].a0, vecs[v].d0);
            step(0, 1, vecs[v].a1, vecs[v].d1);
            seek(vecs[v].s, found);
            chk($sformatf("v%0d_seek_s%0d", v, vecs[v].s), int'(found), 1);
            chk($sformatf("v%0d_fnum", v),  int'(fnum_I),  int'(vecs[v].fnum));
            chk($sformatf("v%0d_block", v), int'(block_I), int'(vecs[v].blk));
            chk($sformatf("v%0d_viben", v), int'(viben_I), int'(vecs[v].vib));
            step(1, 0, 8'h00, 8'h00);
            chk($sformatf("v%0d_mul", v),   int'(mul_II),  int'(vecs[v].mul));
        end

        // Key-on of channel 0: one pulse at stage-II slot 3, then at slot 0 (first visit after write).
        do_reset();
        step(0, 1, 8'hB0, 8'h20);
        for (int k = 1; k <= 72; k++) begin
            step(1, 0, 8'h00, 8'h00);
            chk($sformatf("kon_pg[k=%0d]", k), int'(pg_rst_II), (k == 4 || k == 19) ? 1 : 0);
        end
        // Off/on toggle between visits must not retrigger.
        step(0, 1, 8'hB0, 8'h00);
        step(0, 1, 8'hB0, 8'h20);
        for (int k = 0; k < 36; k++) begin
            step(1, 0, 8'h00, 8'h00);
            chk($sformatf("toggle_pg[%0d]", k), int'(pg_rst_II), 0);
        end
        // Key-off held for a full frame re-arms both operators.
        step(0, 1, 8'hB0, 8'h00);
        for (int k = 0; k < 18; k++) step(1, 0, 8'h00, 8'h00);
        step(0, 1, 8'hB0, 8'h20);
        pulses = 0;
        for (int k = 0; k < 19; k++) begin
            step(1, 0, 8'h00, 8'h00);
            if (pg_rst_II) pulses++;
        end
        chk("rekon_pulses", pulses, 2);

        // Write and cenop in the same cycle: stage I sees the old value.
        do_reset();
        seek(17, found);
        chk("ovl_seek", int'(found), 1);
        step(1, 1, 8'hA0, 8'h11);
        chk("ovl_slot", int'(slot), 18'h1);
        chk("ovl_old_fnum", int'(fnum_I), 0);
        for (int k = 0; k < 18; k++) step(1, 0, 8'h00, 8'h00);
        chk("ovl_new_fnum", int'(fnum_I), 10'h011);
        // cenop low: outputs hold while writes still land.
        for (int k = 0; k < 5; k++) step(0, 1, 8'hA0, 8'h22);
        step(0, 1, 8'h26, 8'hFF);
        step(0, 1, 8'hBD, 8'h60);
        chk("hold_slot", int'(slot), 18'h1);
        chk("hold_fnum", int'(fnum_I), 10'h011);
        chk("bd_vib_dep", int'(vib_dep), 1);
        chk("bd_rhy_en", int'(rhy_en), 1);
        step(1, 0, 8'h00, 8'h00);
        chk("no_op_change_mul", int'(mul_II), 0);
        step(0, 1, 8'hBD, 8'h9F);
        chk("bd_clear", int'({vib_dep, rhy_en}), 0);
        step(0, 1, 8'hBD, 8'h60);

        // Reset overrides a simultaneous cenop and write.
        for (int k = 0; k < 5; k++) step(1, 0, 8'h00, 8'h00);
        rst = 1'b1;
        step(1, 1, 8'hBD, 8'h40);
        rst = 1'b0;
        chk("midrst_slot", int'(slot), 18'h1);
        chk("midrst_bd", int'({vib_dep, rhy_en}), 0);
        seek(0, found);
        chk("midrst_fnum_cleared", int'(fnum_I), 0);

        // Vibrato step: one increment every 1024 frames.
        do_reset();
        for (int k = 0; k < 1024 * 18 - 1; k++) step(1, 0, 8'h00, 8'h00);
        chk("vib_before", int'(vib_cnt), 0);
        step(1, 0, 8'h00, 8'h00);
        chk("vib_one", int'(vib_cnt), 1);
        for (int k = 0; k < 1024 * 18; k++) step(1, 0, 8'h00, 8'h00);
        chk("vib_two", int'(vib_cnt), 2);
        for (int k = 0; k < 6 * 1024 * 18; k++) step(1, 0, 8'h00, 8'h00);
        chk("vib_wrap", int'(vib_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/jtopl_pg_feed.md
JTOPL_PG_FEED -- requirements
Module: jtopl_pg_feed

Interface
REQ-001 Parameter: CH, default 9, number of channels; slot count is 2*CH.
REQ-002 Port: rst  in  1  synchronous active-high reset, sampled on posedge clk.
REQ-003 Port: clk  in  1  system clock; the block uses only its rising edge.
REQ-004 Port: cenop  in  1  operator clock enable; one slot advance per asserted cycle.
REQ-005 Port: wr  in  1  register write strobe, one clk per write, not gated by cenop.
REQ-006 Port: addr  in  8  register address.
REQ-007 Port: din  in  8  register write data.
REQ-008 Port: slot  out  18  one-hot current stage-I slot.
REQ-009 Port: fnum_I  out  10  channel F-number for the stage-I slot.
REQ-010 Port: block_I  out  3  channel block for the stage-I slot.
REQ-011 Port: viben_I  out  1  operator vibrato enable for the stage-I slot.
REQ-012 Port: mul_II  out  4  operator multiplier for the previous slot (stage II).
REQ-013 Port: pg_rst_II  out  1  phase reset for the stage-II slot.
REQ-014 Port: vib_cnt  out  3  vibrato LFO step.
REQ-015 Port: vib_dep  out  1  vibrato depth, register 0xBD bit 6.
REQ-016 Port: rhy_en  out  1  rhythm mode, register 0xBD bit 5.

Function
REQ-017 Slot counter s runs 0..17 and advances on cenop; 17 wraps to 0; slot = 1<<s.
REQ-018 Slot decode: g = s/6, w = s%6; channel = 3g + (w%3); operator register offset = 8g + w.
REQ-019 Register 0x20+off, off in {0-5, 8-D, 10-15}: bit6 -> vib, bits3:0 -> mul of that operator.
REQ-020 Register 0xA0+c, c in 0..8: fnum[7:0] of channel c.
REQ-021 Register 0xB0+c: bit5 -> kon, bits4:2 -> block, bits1:0 -> fnum[9:8] of channel c.
REQ-022 Register 0xBD: bit6 -> vib_dep, bit5 -> rhy_en; other bits are ignored.
REQ-023 All other addresses, including 0x26, 0x27, 0x2E, 0x2F, 0xA9-0xAF and 0xB9-0xBC, are ignored.
REQ-024 Writes take effect on the clk edge where wr is high; a write and a cenop in the same cycle read the pre-write value.
REQ-025 slot, fnum_I, block_I and viben_I are registered on cenop together and are mutually aligned.
REQ-026 mul_II and pg_rst_II are registered one cenop after the stage-I data of the same slot.
REQ-027 Each slot keeps a kon_seen bit; at stage I: pg = kon & ~kon_seen[s], then kon_seen[s] <= kon.
REQ-028 pg is delivered at stage II as pg_rst_II; it lasts exactly one slot.
REQ-029 A kon 0->1->0 toggle completed between two visits of the same slot produces no pg_rst_II.
REQ-030 A frame counter increments when s wraps 17->0; vib_cnt increments (mod 8) when the frame counter wraps 1023->0.
REQ-031 With cenop low, all outputs and counters hold; register writes still apply.

Reset
REQ-032 On rst: s = 0, slot = 18'h1, all register fields = 0, all kon_seen bits = 0, frame counter = 0.
REQ-033 On rst: vib_cnt = 0, vib_dep = 0, rhy_en = 0, fnum_I = 0, block_I = 0, viben_I = 0, mul_II = 0, pg_rst_II = 0.
REQ-034 Reset asserted mid-frame overrides both cenop and wr in that cycle.

Structure
REQ-035 A shared package holds constants for the slot count (18), register bases (0x20, 0xA0, 0xB0, 0xBD), and the vibrato frame period (1024).
REQ-036 A single sub-module, jtopl_slot_cnt, implements the slot counter, frame counter and vib_cnt; register storage stays in jtopl_pg_feed.

Verification
REQ-037 Bench shall cover: rst, then 18 cenop -> slot walks 0x1 to 0x20000 and returns to 0x1; all data outputs stay 0.
REQ-038 Bench shall cover: write 0xA4=0x55, then 0xB4=0x3A -> at slots whose channel is 4 (s=7 and s=10): fnum_I=0x255, block_I=6.
REQ-039 Bench shall cover: write 0x33=0x4C -> one cenop after slot s=15: mul_II=0xC; viben_I=1 at s=15.
REQ-040 Bench shall cover: kon on for channel 0 -> pg_rst_II=1 exactly once at each of s=0 and s=3, then 0 on later frames.
REQ-041 Bench shall cover: 1024*18 cenop -> vib_cnt=1; after 8 such periods vib_cnt=0.
REQ-042 Bench shall cover: write 0x26=0xFF and 0xBD=0x60 -> no operator changes; vib_dep=1 and rhy_en=1.
